c_loader: RTL and testbench
===========================

# c_loader

Boot image loader that receives a byte stream, assembles little-endian 32-bit words, writes them into BA22 instruction/data RAM and, after a checksum check, asserts `load_done`. It is the producer of the `load_done` signal consumed by the clock/reset generator `c_clgen`. While `load_done` is low, `c_clgen` keeps the core clock gated and the core in reset.

## Interface
- `ADDR_W`, default 12: RAM word-address width.
- `BASE_ADDR`, default 0: word address of the first payload word.

Ports:
- `clk`  in  1  board clock; same clock as `c_clgen`.
- `KEY`  in  1  reset; one clock; reset is asynchronous and active-low.
- `byte_i`  in  8  incoming stream byte.
- `byte_valid_i`  in  1  `byte_i` is valid.
- `byte_ready_o`  out  1  loader accepts a byte this cycle.
- `mem_addr_o`  out  ADDR_W  RAM word address.
- `mem_data_o`  out  32  RAM write data.
- `mem_we_o`  out  1  one-cycle RAM write strobe.
- `word_cnt_o`  out  16  number of words written so far.
- `load_done`  out  1  image loaded and verified; sticky until reset.
- `error_o`  out  1  length or checksum error; sticky until reset.

## Operation
- A byte is accepted on the rising edge where `byte_valid_i && byte_ready_o`. No other cycle consumes a byte.
- Stream format:
  - LEN_LO, LEN_HI: 16-bit word count N, little-endian.
  - N×4 payload bytes, least-significant byte of each word first.
  - CKSUM: 8-bit sum, mod 256, of all payload bytes.
- FSM states: HDR0, HDR1, DATA, CKSUM, DONE, ERROR.
  - HDR0: accept LEN_LO, then go to HDR1.
  - HDR1: accept LEN_HI.
    - If N > 2^ADDR_W − BASE_ADDR, go to ERROR.
    - Else if N == 0, go to CKSUM.
    - Else go to DATA.
  - DATA: a 2-bit byte-lane counter shifts each byte into its lane. On the 4th byte, capture the word, pulse a write and increment the word index. After word N is captured, go to CKSUM.
  - CKSUM: accept one byte.
    - If it equals the running sum, go to DONE.
    - Otherwise go to ERROR.
  - DONE: `load_done`=1. No further bytes are accepted.
  - ERROR: `error_o`=1, `load_done`=0. No further bytes are accepted.
- `byte_ready_o` = 1 in HDR0, HDR1, DATA and CKSUM; 0 in DONE and ERROR; 0 while `KEY`=0.
- Running sum: 8-bit, wraps mod 256. It accumulates payload bytes only, never header or checksum bytes.
- Word address of word k (k = 0…N−1) = BASE_ADDR + k, truncated to ADDR_W bits. The length check guarantees no wrap.
- `word_cnt_o` increments together with each `mem_we_o` pulse.
- The only exits from DONE and ERROR are through reset.

## Timing
- Reset values (asynchronous while `KEY`=0):
  - state = HDR0.
  - `mem_addr_o`=0, `mem_data_o`=0, `mem_we_o`=0, `word_cnt_o`=0.
  - `load_done`=0, `error_o`=0, running sum = 0, lane counter = 0.
- After `KEY` rises, `byte_ready_o`=1 from the first clock edge onward.
- Write latency: `mem_we_o` is high for exactly the one cycle after the edge that accepts the 4th byte of a word. `mem_addr_o` and `mem_data_o` are valid in that same cycle. `mem_addr_o` and `mem_data_o` hold their values until the next write.
- The RAM accepts a write every cycle, so the loader never stalls. Back-to-back valid bytes give one write every 4 cycles.
- `load_done` rises in the cycle after the checksum byte is accepted; `error_o` rises in the cycle after the failing byte is accepted. Both are registered outputs. Neither ever falls except on reset.
- The final word's `mem_we_o` pulse occurs no later than the cycle in which CKSUM is first ready. `load_done` is therefore never asserted before the last write completes.
- Gaps (`byte_valid_i`=0) may occur at any point. State, lane counter and sum hold during a gap.
- Reset mid-load: `load_done` and `mem_we_o` drop immediately, which re-gates the core clock in `c_clgen`. The partial RAM contents are don't-care. The next image restarts at HDR0.

## Test plan
- N=1, bytes 01 00 78 56 34 12 14:
  - one write: addr 0, data 0x12345678;
  - `load_done`=1 one cycle after the 0x14 byte;
  - `word_cnt_o`=1, `error_o`=0.
- N=0, bytes 00 00 00: no write; `load_done`=1 one cycle after the 3rd byte.
- N=2 with a random `byte_valid_i` duty of about 30%:
  - writes at addr 0 and addr 1, each exactly one cycle wide;
  - sum wraps correctly, e.g. payload bytes all 0xFF give CKSUM 0xF8;
  - `load_done`=1.
- Bad checksum: N=1, payload 78 56 34 12, CKSUM 0x15:
  - the write still occurs;
  - `error_o`=1, `load_done` stays 0;
  - `byte_ready_o`=0 afterwards.
- Length error with ADDR_W=12, BASE_ADDR=0: header 01 10 (N=4097) → `error_o`=1 after LEN_HI and no writes.
- `KEY` pulled low in the middle of word 3 of an N=8 load:
  - all outputs return to reset values asynchronously;
  - a full N=1 image loaded afterwards writes addr 0 and ends with `load_done`=1.

Source files
------------

// File: rtl/c_loader.sv
// Boot image loader: parses a length-prefixed byte stream, writes little-endian
// 32-bit words into instruction/data RAM and raises load_done once the checksum matches.
module c_loader #(
    parameter int ADDR_W    = 12,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              KEY,
    input  logic [7:0]        byte_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_data_o,
    output logic              mem_we_o,
    output logic [15:0]       word_cnt_o,
    output logic              load_done,
    output logic              error_o
);

    typedef enum logic [2:0] {HDR0, HDR1, DATA, CKSUM, DONE, ERROR} state_t;

    // Number of words that fit between BASE_ADDR and the top of the RAM.
    localparam longint unsigned CAPACITY = (64'd1 << ADDR_W) - 64'(BASE_ADDR);

    state_t            state_q, state_d;
    logic              accept;
    logic [7:0]        len_lo_q;
    logic [15:0]       len_q;
    logic [15:0]       hdr_len;
    logic [1:0]        lane_q;
    logic [23:0]       shift_q;
    logic [7:0]        sum_q;
    logic [ADDR_W-1:0] next_addr_q;

    // KEY gates ready directly so no byte is taken while reset is held.
    assign byte_ready_o = KEY && (state_q inside {HDR0, HDR1, DATA, CKSUM});
    assign accept       = byte_valid_i && byte_ready_o;
    assign hdr_len      = {byte_i, len_lo_q};

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge KEY) begin
        if (!KEY) state_q <= HDR0;
        else      state_q <= state_d;
    end

    // NOTE: state_d takes its default first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            HDR0:  if (accept) state_d = HDR1;
            HDR1: begin
                if (accept) begin
                    if (64'(hdr_len) > CAPACITY) state_d = ERROR;
                    else if (hdr_len == 16'd0)   state_d = CKSUM;
                    else                         state_d = DATA;
                end
            end
            DATA: begin
                if (accept && lane_q == 2'd3 && word_cnt_o + 16'd1 == len_q)
                    state_d = CKSUM;
            end
            CKSUM: begin
                if (accept) state_d = (byte_i == sum_q) ? DONE : ERROR;
            end
            default: state_d = state_q;
        endcase
    end

    // NOTE: every datapath register is reset, including the byte shifter, so outputs are clean after KEY.
    always_ff @(posedge clk or negedge KEY) begin
        if (!KEY) begin
            len_lo_q    <= '0;
            len_q       <= '0;
            lane_q      <= '0;
            shift_q     <= '0;
            sum_q       <= '0;
            next_addr_q <= ADDR_W'(BASE_ADDR);
            mem_addr_o  <= '0;
            mem_data_o  <= '0;
            mem_we_o    <= 1'b0;
            word_cnt_o  <= '0;
            load_done   <= 1'b0;
            error_o     <= 1'b0;
        end else begin
            mem_we_o <= 1'b0;
            if (accept && state_q == HDR0) len_lo_q <= byte_i;
            if (accept && state_q == HDR1) len_q    <= hdr_len;
            if (accept && state_q == DATA) begin
                sum_q  <= sum_q + byte_i;
                lane_q <= lane_q + 2'd1;
                if (lane_q == 2'd3) begin
                    // Earlier lanes sit in shift_q oldest-lowest, giving little-endian order.
                    mem_we_o    <= 1'b1;
                    mem_data_o  <= {byte_i, shift_q};
                    mem_addr_o  <= next_addr_q;
                    next_addr_q <= next_addr_q + 1'b1;
                    word_cnt_o  <= word_cnt_o + 16'd1;
                end else begin
                    shift_q <= {byte_i, shift_q[23:8]};
                end
            end
            if (state_d == DONE)  load_done <= 1'b1;
            if (state_d == ERROR) error_o   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_c_loader.sv
// Randomized self-checking bench for c_loader: a stream-index model predicts
// every accept, write, status flag and ready value cycle by cycle.
module tb_c_loader;

    localparam int ADDR_W    = 12;
    localparam int BASE_ADDR = 0;

    logic              clk = 1'b0;
    logic              KEY;
    logic [7:0]        byte_i;
    logic              byte_valid_i;
    logic              byte_ready_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_data_o;
    logic              mem_we_o;
    logic [15:0]       word_cnt_o;
    logic              load_done;
    logic              error_o;

    always #5 clk = ~clk;

    c_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
        .clk          (clk),
        .KEY          (KEY),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_we_o     (mem_we_o),
        .word_cnt_o   (word_cnt_o),
        .load_done    (load_done),
        .error_o      (error_o)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Model: the stream being offered plus what its byte positions imply.
    logic [7:0]        stream[$];
    int                acc_cnt;
    int                limit;
    int                n_words;
    bit                len_bad;
    int                duty;
    bit                check_en = 1'b0;
    logic              exp_we;
    logic [ADDR_W-1:0] exp_addr;
    logic [31:0]       exp_data;
    logic [15:0]       exp_cnt;
    logic              exp_done;
    logic              exp_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic bit model_ready();
        return (KEY === 1'b1) && (acc_cnt < limit);
    endfunction

    task automatic model_reset();
        acc_cnt  = 0;
        exp_we   = 1'b0;
        exp_addr = '0;
        exp_data = '0;
        exp_cnt  = '0;
        exp_done = 1'b0;
        exp_err  = 1'b0;
    endtask

    // Derive image length, length verdict and the number of bytes the loader may take.
    task automatic configure();
        n_words = int'({stream[1], stream[0]});
        len_bad = n_words > ((1 << ADDR_W) - BASE_ADDR);
        limit   = len_bad ? 2 : 2 + 4 * n_words + 1;
    endtask

    task automatic step();
        bit   acc;
        int   idx;
        int   k;
        logic [7:0] s;
        @(posedge clk);
        acc    = byte_valid_i && model_ready();
        exp_we = 1'b0;
        if (acc) begin
            idx = acc_cnt;
            acc_cnt++;
            if (len_bad && idx == 1) exp_err = 1'b1;
            if (!len_bad && idx >= 2 && idx < 2 + 4 * n_words && (idx - 2) % 4 == 3) begin
                k        = (idx - 2) / 4;
                exp_we   = 1'b1;
                exp_addr = ADDR_W'(BASE_ADDR + k);
                exp_data = {stream[idx], stream[idx-1], stream[idx-2], stream[idx-3]};
                exp_cnt  = 16'(k + 1);
            end
            if (!len_bad && idx == 2 + 4 * n_words) begin
                s = 8'd0;
                for (int i = 2; i < 2 + 4 * n_words; i++) s = s + stream[i];
                if (stream[idx] == s) exp_done = 1'b1;
                else                  exp_err  = 1'b1;
            end
        end
        #1;
        byte_valid_i = ($urandom_range(99) < duty);
        byte_i       = (acc_cnt < stream.size()) ? stream[acc_cnt] : 8'($urandom);
    endtask

    // Enter reset with the next image already loaded into the model, then release.
    task automatic reset_into(input int d);
        KEY          = 1'b0;
        byte_valid_i = 1'b0;
        duty         = d;
        model_reset();
        configure();
        repeat (2) @(posedge clk);
        #3;
        KEY = 1'b1;
    endtask

    task automatic run_image(input int d);
        int cyc;
        reset_into(d);
        cyc = 0;
        while (acc_cnt < limit && cyc < 30000) begin
            step();
            cyc++;
        end
        check("accepted_bytes", acc_cnt, limit);
        repeat (6) step();
    endtask

    task automatic build(input int n, input bit bad);
        logic [7:0] s;
        logic [7:0] b;
        s = 8'd0;
        stream = {};
        stream.push_back(n[7:0]);
        stream.push_back(n[15:8]);
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            stream.push_back(b);
            s = s + b;
        end
        stream.push_back(bad ? 8'(s + 8'($urandom_range(1, 255))) : s);
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check("byte_ready", byte_ready_o, model_ready());
            check("mem_we",     mem_we_o,     exp_we);
            check("mem_addr",   mem_addr_o,   exp_addr);
            check("mem_data",   mem_data_o,   exp_data);
            check("word_cnt",   word_cnt_o,   exp_cnt);
            check("load_done",  load_done,    exp_done);
            check("error",      error_o,      exp_err);
        end
    end

    initial begin
        KEY          = 1'b0;
        byte_i       = 8'd0;
        byte_valid_i = 1'b0;
        duty         = 100;
        stream       = '{8'h00, 8'h00, 8'h00};
        model_reset();
        configure();
        #2;
        check("rst_ready", byte_ready_o, 1'b0);
        check("rst_done",  load_done,    1'b0);
        check("rst_we",    mem_we_o,     1'b0);
        check_en = 1'b1;

        // N=1 single word
        stream = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h14};
        run_image(100);
        check("t1_data", mem_data_o, 32'h12345678);
        check("t1_addr", mem_addr_o, 32'd0);
        check("t1_cnt",  word_cnt_o, 32'd1);
        check("t1_done", load_done,  1'b1);
        check("t1_err",  error_o,    1'b0);

        // N=0 empty image
        stream = '{8'h00, 8'h00, 8'h00};
        run_image(100);
        check("t2_cnt",  word_cnt_o, 32'd0);
        check("t2_done", load_done,  1'b1);

        // N=2 all 0xFF, sparse valid, sum wraps to 0xF8
        stream = '{8'h02, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF8};
        run_image(30);
        check("t3_data", mem_data_o, 32'hFFFFFFFF);
        check("t3_addr", mem_addr_o, 32'd1);
        check("t3_cnt",  word_cnt_o, 32'd2);
        check("t3_done", load_done,  1'b1);

        // Bad checksum
        stream = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h15};
        run_image(100);
        check("t4_cnt",   word_cnt_o,   32'd1);
        check("t4_err",   error_o,      1'b1);
        check("t4_done",  load_done,    1'b0);
        check("t4_ready", byte_ready_o, 1'b0);

        // Length one past capacity
        stream = '{8'h01, 8'h10, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        run_image(100);
        check("t5_err", error_o,    1'b1);
        check("t5_cnt", word_cnt_o, 32'd0);

        // Reset in the middle of word 3 of an N=8 load
        build(8, 1'b0);
        reset_into(100);
        while (acc_cnt < 2 + 8 + 2) step();
        #2;
        KEY = 1'b0;
        model_reset();
        #1;
        check("mid_ready", byte_ready_o, 1'b0);
        check("mid_we",    mem_we_o,     1'b0);
        check("mid_addr",  mem_addr_o,   32'd0);
        check("mid_data",  mem_data_o,   32'd0);
        check("mid_cnt",   word_cnt_o,   32'd0);
        check("mid_done",  load_done,    1'b0);
        stream = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h38};
        run_image(100);
        check("t6_data", mem_data_o, 32'hDEADBEEF);
        check("t6_addr", mem_addr_o, 32'd0);
        check("t6_done", load_done,  1'b1);

        // Full-capacity image: last word lands at the top address
        build(1 << ADDR_W, 1'b0);
        run_image(100);
        check("t7_addr", mem_addr_o, 32'hFFF);
        check("t7_cnt",  word_cnt_o, 32'd4096);
        check("t7_done", load_done,  1'b1);

        // Random images
        for (int t = 0; t < 10; t++) begin
            build($urandom_range(0, 6), $urandom_range(3) == 0);
            run_image($urandom_range(20, 100));
        end

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
